// File: rtl/gold_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gold_pkg
//  Brief    : Shared constants and types for the gold-coin strip
//             (counter, region producer and bitmap)
//  Revision : 1.0 - initial release
// ============================================================================
package gold_pkg;

    localparam int MAX_COINS       = 5;   // count ceiling
    localparam int COIN_WIDTH_X    = 20;  // pixels per coin along X
    localparam int OBJECT_HEIGHT_Y = 16;  // strip height in rows

    typedef logic [2:0]  gold_t;
    typedef logic [10:0] coord_t;

endpackage : gold_pkg
`default_nettype wire

// File: rtl/gold_count_reg.sv
`default_nettype none
// ============================================================================
//  Module   : gold_count_reg
//  Brief    : Saturating gold counter with +1 / -1 requests and single-cycle
//             spend accepted / spend denied pulses
//  Revision : 1.0 - initial release
// ============================================================================
module gold_count_reg
    import gold_pkg::*;
#(
    parameter int MAX_COINS = gold_pkg::MAX_COINS
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  add,
    input  logic  spend,
    output gold_t count,
    output logic  spend_ok,
    output logic  spend_denied
);

    gold_t r_count;
    logic  r_spend_ok;
    logic  r_spend_denied;

    // Count update and spend-result pulses; simultaneous add+spend is a
    // net-zero trade that is always accepted, even at 0 or at the ceiling.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count        <= '0;
            r_spend_ok     <= 1'b0;
            r_spend_denied <= 1'b0;
        end else begin
            r_spend_ok     <= 1'b0;
            r_spend_denied <= 1'b0;
            case ({add, spend})
                2'b10: begin
                    if (r_count < gold_t'(MAX_COINS)) begin
                        r_count <= r_count + gold_t'(1);
                    end
                end
                2'b01: begin
                    if (r_count != '0) begin
                        r_count    <= r_count - gold_t'(1);
                        r_spend_ok <= 1'b1;
                    end else begin
                        r_spend_denied <= 1'b1;
                    end
                end
                2'b11: begin
                    r_spend_ok <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign count        = r_count;
    assign spend_ok     = r_spend_ok;
    assign spend_denied = r_spend_denied;

endmodule : gold_count_reg
`default_nettype wire

// File: rtl/gold_count_square_object.sv
`default_nettype none
// ============================================================================
//  Module   : gold_count_square_object
//  Brief    : Gold-counter strip producer: owns the gold count, latches the
//             displayed count at frame start, blinks after changes and drives
//             bitmap offsets / inside flag with one cycle of latency
//  Revision : 1.0 - initial release
// ============================================================================
module gold_count_square_object
    import gold_pkg::*;
#(
    parameter coord_t TOP_LEFT_X      = 11'd520,
    parameter coord_t TOP_LEFT_Y      = 11'd16,
    parameter int     OBJECT_HEIGHT_Y = gold_pkg::OBJECT_HEIGHT_Y,
    parameter int     COIN_WIDTH_X    = gold_pkg::COIN_WIDTH_X,
    parameter int     MAX_COINS       = gold_pkg::MAX_COINS,
    parameter int     FLASH_FRAMES    = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [10:0]  pixelX,
    input  logic [10:0]  pixelY,
    input  logic         startOfFrame,
    input  logic         goldAdd,
    input  logic         goldSpend,
    output logic [10:0]  offsetX,
    output logic [10:0]  offsetY,
    output logic         InsideRectangle,
    output logic         spendOk,
    output logic         spendDenied,
    output logic [2:0]   goldCount
);

    localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

    gold_t               w_gold_count;
    gold_t               r_display_count;
    logic [FLASH_W-1:0]  r_flash_cnt;
    logic [3:0]          r_frame_cnt;
    coord_t              r_offset_x;
    coord_t              r_offset_y;
    logic                r_inside;

    coord_t              w_right_edge;
    coord_t              w_bottom_edge;
    logic                w_inside_raw;
    logic                w_hide;
    logic                w_inside;

    gold_count_reg #(
        .MAX_COINS    (MAX_COINS)
    ) u_gold_count_reg (
        .clk          (clk),
        .reset        (reset),
        .add          (goldAdd),
        .spend        (goldSpend),
        .count        (w_gold_count),
        .spend_ok     (spendOk),
        .spend_denied (spendDenied)
    );

    // Frame-start bookkeeping: latch the shown count (pre-update value if a
    // request lands on the same edge) and restart the blink on any change.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_display_count <= '0;
            r_flash_cnt     <= '0;
            r_frame_cnt     <= '0;
        end else if (startOfFrame) begin
            r_frame_cnt     <= r_frame_cnt + 4'd1;
            r_display_count <= w_gold_count;
            if (w_gold_count != r_display_count) begin
                r_flash_cnt <= FLASH_W'(FLASH_FRAMES);
            end else if (r_flash_cnt != '0) begin
                r_flash_cnt <= r_flash_cnt - FLASH_W'(1);
            end
        end
    end

    // Visible region grows with the displayed coin count; zero coins is empty.
    assign w_right_edge  = TOP_LEFT_X + coord_t'(r_display_count) * coord_t'(COIN_WIDTH_X);
    assign w_bottom_edge = TOP_LEFT_Y + coord_t'(OBJECT_HEIGHT_Y);
    assign w_inside_raw  = (pixelX >= TOP_LEFT_X) && (pixelX < w_right_edge) &&
                           (pixelY >= TOP_LEFT_Y) && (pixelY < w_bottom_edge);
    assign w_hide        = (r_flash_cnt != '0) && r_frame_cnt[2];
    assign w_inside      = w_inside_raw && !w_hide;

    // Registered bitmap address; offsets forced to 0 outside so the bitmap
    // index is always in range.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inside   <= 1'b0;
            r_offset_x <= '0;
            r_offset_y <= '0;
        end else begin
            r_inside   <= w_inside;
            r_offset_x <= w_inside ? (pixelX - TOP_LEFT_X) : '0;
            r_offset_y <= w_inside ? (pixelY - TOP_LEFT_Y) : '0;
        end
    end

    assign offsetX         = r_offset_x;
    assign offsetY         = r_offset_y;
    assign InsideRectangle = r_inside;
    assign goldCount       = w_gold_count;

endmodule : gold_count_square_object
`default_nettype wire

// File: doc/gold_count_square_object.md
Name: gold_count_square_object

Overview:
- Producer side of the gold-counter bitmap interface. Receives VGA pixel coordinates and drives offsetX, offsetY and InsideRectangle into the 16-row x 100-column gold-coin strip bitmap, which holds 5 coins of 20 px each.
- Owns the player's gold count as a saturating register with add/spend requests. Exposes only the first displayCount coins.
- Displayed count updates only at frame start, to avoid tearing. The strip blinks for a fixed number of frames after any count change.

Parameters:
- TOP_LEFT_X, 11'd520, strip left edge in pixels
- TOP_LEFT_Y, 11'd16, strip top edge in pixels
- OBJECT_HEIGHT_Y, 16, strip height in rows (bitmap first index)
- COIN_WIDTH_X, 20, pixels per coin along X (bitmap second index)
- MAX_COINS, 5, count ceiling; MAX_COINS*COIN_WIDTH_X = 100
- FLASH_FRAMES, 32, frames of blinking after a displayed-count change

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pixelX  in  11  current VGA column
- pixelY  in  11  current VGA row
- startOfFrame  in  1  one-cycle pulse at the first pixel of each frame
- goldAdd  in  1  one-cycle request: +1 coin
- goldSpend  in  1  one-cycle request: -1 coin
- offsetX  out  11  pixelX - TOP_LEFT_X when inside, else 0
- offsetY  out  11  pixelY - TOP_LEFT_Y when inside, else 0
- InsideRectangle  out  1  pixel lies in the visible coin region
- spendOk  out  1  pulse: spend accepted
- spendDenied  out  1  pulse: spend rejected (no gold)
- goldCount  out  3  live count 0..MAX_COINS

Behaviour:
- Reset (synchronous, clk edge with reset=1) sets every output to 0, plus: goldCount=0, displayCount=0, flashCnt=0, frameCnt=0.
  - Reset has priority over all inputs, including mid-flash and mid-request.
- Count register, updated at each clk edge:
  - add only: count+1, saturating at MAX_COINS. An add at MAX is silently dropped.
  - spend only, count>0: count-1, spendOk=1 next cycle.
  - spend only, count=0: count unchanged, spendDenied=1 next cycle.
  - add and spend in the same cycle: count unchanged, spendOk=1. Holds at count 0 and at MAX.
  - spendOk and spendDenied are single-cycle and never both 1.
- Frame logic, on startOfFrame=1:
  - frameCnt (4 bit) increments and wraps.
  - displayCount <= goldCount. If displayCount changes, flashCnt <= FLASH_FRAMES, otherwise flashCnt decrements toward 0, saturating.
  - If a count update and startOfFrame coincide, displayCount takes the pre-update goldCount. The new value shows next frame.
- Region test, combinational from pixel inputs:
  - insideRaw = (pixelX >= TOP_LEFT_X) && (pixelX < TOP_LEFT_X + displayCount*COIN_WIDTH_X) && (pixelY >= TOP_LEFT_Y) && (pixelY < TOP_LEFT_Y + OBJECT_HEIGHT_Y).
  - Width math is 11-bit unsigned. Parameters must keep the right edge < 2048.
  - displayCount=0 gives an empty region.
- Blink mask: hide = (flashCnt != 0) && frameCnt[2], i.e. the strip toggles every 4 frames while flashing.
- Output register, 1-cycle latency from pixelX/pixelY to outputs:
  - InsideRectangle <= insideRaw && !hide.
  - offsetX and offsetY <= the subtractions when InsideRectangle is set, else 0.
  - offsetY range 0..15, offsetX range 0..displayCount*20-1, always within bitmap bounds.
  - Bitmap adds one more cycle, so total pixel-to-RGB latency is 2 cycles. The VGA mux compensates.

Decomposition:
- Package gold_pkg holds:
  - MAX_COINS, COIN_WIDTH_X, OBJECT_HEIGHT_Y
  - typedef logic [2:0] gold_t
  - typedef logic [10:0] coord_t
  - the bitmap module also uses these constants.
- One natural sub-module: gold_count_reg. It covers the add/spend saturation and the spendOk/spendDenied pulses, and is reused by the shop logic.
- Region, frame and blink logic stay in the top level.

Test Plan:
- Reset, then 6 goldAdd pulses -> goldCount=5, no wrap to 0. After next startOfFrame, pixel (619,16) gives InsideRectangle=1, offsetX=99, offsetY=0 one cycle later.
- goldCount=0, goldSpend -> spendDenied=1 for exactly one cycle, spendOk=0, count stays 0.
- goldCount=2, add and spend in the same cycle -> count=2, spendOk=1. At count=0 the same stimulus gives count=0, spendOk=1.
- displayCount=2, pixel (560,20) -> InsideRectangle=0 and offsets 0. Pixel (559,31) -> InsideRectangle=1, offsetX=39, offsetY=15. Pixel (559,32) -> 0.
- Count change 2->3 -> strip unchanged until next startOfFrame. Then for 32 frames the region is hidden whenever frameCnt[2]=1. From frame 33 it is steady visible with width 60.
- Assert reset mid-flash while goldSpend is high -> next cycle all outputs 0 and no spendOk. After release, the region stays empty.
